// File: rtl/lock_controller_pkg.sv
// Shared types and ASCII constants for the keypad lock controller.
package lock_pkg;

    typedef enum logic [2:0] {
        StEntry,
        StCheck,
        StResp,
        StUnlocked,
        StLockout
    } state_e;

    localparam logic [7:0] ZERO      = 8'h30;
    localparam logic [7:0] NINE      = 8'h39;
    localparam logic [7:0] STAR      = 8'h2A;
    localparam logic [7:0] ST_OK     = 8'h4F;
    localparam logic [7:0] ST_FAIL   = 8'h58;
    localparam logic [7:0] ST_LOCK   = 8'h4C;
    localparam logic [7:0] ST_RELOCK = 8'h52;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ZERO) && (b <= NINE);
    endfunction

endpackage

// File: rtl/lock_controller_if.sv
// UART-side and actuator-side signals of the lock controller.
interface lock_controller_if #(
    parameter int unsigned MAX_FAIL = 3
) ();
    localparam int unsigned FAIL_W = $clog2(MAX_FAIL + 1);

    logic [7:0]        rx_data;
    logic              rx_done;
    logic              tx_busy;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              unlocked;
    logic              lockout;
    logic [FAIL_W-1:0] fail_count;

    modport master (
        output rx_data, rx_done, tx_busy,
        input  tx_data, tx_start, unlocked, lockout, fail_count
    );

    modport slave (
        input  rx_data, rx_done, tx_busy,
        output tx_data, tx_start, unlocked, lockout, fail_count
    );
endinterface

// File: rtl/lock_controller_hold_timer.sv
// Down-counter shared by the unlock hold and the lockout period.
module hold_timer #(
    parameter int unsigned WIDTH = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_expire
);

    logic [WIDTH-1:0] r_count;
    logic             r_armed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_armed <= 1'b0;
        end else if (i_load) begin
            r_count <= i_load_val;
            r_armed <= 1'b1;
        end else if (r_armed) begin
            if (r_count == '0) begin
                r_armed <= 1'b0;
            end else begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Loaded with N-1 so the pulse lands on the N-th cycle after the load edge.
    assign o_expire = r_armed && (r_count == '0);

endmodule

// File: rtl/lock_controller.sv
// Keypad lock sequencer: collects 4-digit entries, checks the code, drives
// unlock/lockout and reports each outcome as one status byte.
module lock_controller
    import lock_pkg::*;
#(
    parameter logic [31:0] CODE           = 32'h31343136,
    parameter int unsigned MAX_FAIL       = 3,
    parameter int unsigned UNLOCK_CYCLES  = 5000,
    parameter int unsigned LOCKOUT_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              reset,
    lock_controller_if.slave  bus
);

    localparam int unsigned FAIL_W    = $clog2(MAX_FAIL + 1);
    localparam int unsigned TIMER_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ?
                                        UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int unsigned TIMER_W   = $clog2(TIMER_MAX);
    localparam logic [TIMER_W-1:0] UNLOCK_LOAD  = TIMER_W'(UNLOCK_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);

    state_e            r_state;
    logic [1:0]        r_count;
    logic [31:0]       r_entry;
    logic [7:0]        r_status;
    logic [7:0]        r_tx_data;
    logic              r_tx_start;
    logic              r_unlocked;
    logic              r_lockout;
    logic [FAIL_W-1:0] r_fail_count;

    logic               w_send;
    logic               w_load;
    logic [TIMER_W-1:0] w_load_val;
    logic               w_expire;
    logic               w_star;

    assign w_send     = (r_state == StResp) && !bus.tx_busy;
    assign w_load     = w_send && ((r_status == ST_OK) || (r_status == ST_LOCK));
    assign w_load_val = (r_status == ST_OK) ? UNLOCK_LOAD : LOCKOUT_LOAD;
    assign w_star     = bus.rx_done && (bus.rx_data == STAR);

    hold_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_expire   (w_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= StEntry;
            r_count      <= '0;
            r_entry      <= '0;
            r_status     <= '0;
            r_tx_data    <= '0;
            r_tx_start   <= 1'b0;
            r_unlocked   <= 1'b0;
            r_lockout    <= 1'b0;
            r_fail_count <= '0;
        end else begin
            r_tx_start <= 1'b0;
            case (r_state)
                StEntry: begin
                    if (bus.rx_done && is_digit(bus.rx_data)) begin
                        r_entry <= {r_entry[23:0], bus.rx_data};
                        r_count <= r_count + 1'b1;
                        if (r_count == 2'd3) r_state <= StCheck;
                    end else if (w_star) begin
                        r_count <= '0;
                        r_entry <= '0;
                    end
                end
                StCheck: begin
                    r_count <= '0;
                    r_state <= StResp;
                    if (r_entry == CODE) begin
                        r_unlocked   <= 1'b1;
                        r_fail_count <= '0;
                        r_status     <= ST_OK;
                    end else if (int'(r_fail_count) + 1 >= int'(MAX_FAIL)) begin
                        r_lockout    <= 1'b1;
                        r_fail_count <= '0;
                        r_status     <= ST_LOCK;
                    end else begin
                        r_fail_count <= r_fail_count + 1'b1;
                        r_status     <= ST_FAIL;
                    end
                end
                StResp: begin
                    if (w_send) begin
                        r_tx_start <= 1'b1;
                        r_tx_data  <= r_status;
                        if (r_status == ST_OK) begin
                            r_state <= StUnlocked;
                        end else if (r_status == ST_LOCK) begin
                            r_state <= StLockout;
                        end else begin
                            r_state <= StEntry;
                        end
                    end
                end
                StUnlocked: begin
                    if (w_expire || w_star) begin
                        r_unlocked <= 1'b0;
                        r_status   <= ST_RELOCK;
                        r_state    <= StResp;
                    end
                end
                StLockout: begin
                    if (w_expire) begin
                        r_lockout <= 1'b0;
                        r_state   <= StEntry;
                    end
                end
                default: r_state <= StEntry;
            endcase
        end
    end

    assign bus.tx_data    = r_tx_data;
    assign bus.tx_start   = r_tx_start;
    assign bus.unlocked   = r_unlocked;
    assign bus.lockout    = r_lockout;
    assign bus.fail_count = r_fail_count;

endmodule

// File: tb/tb_lock_controller.sv
// Scoreboard bench: stimulus queues the expected status bytes, a monitor
// pops and compares them on every tx_start.
module tb_lock_controller;
    import lock_pkg::*;

    localparam int unsigned UNLOCK  = 60;
    localparam int unsigned LOCKOUT = 40;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   n_tx;
    int   tx_before;
    logic prev_start;
    logic [7:0] exp_q[$];

    lock_controller_if #(.MAX_FAIL(3)) bus ();

    lock_controller #(
        .CODE           (32'h31343136),
        .MAX_FAIL       (3),
        .UNLOCK_CYCLES  (UNLOCK),
        .LOCKOUT_CYCLES (LOCKOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Byte is sampled by the DUT at the second edge; returns 1 time unit after it.
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        bus.rx_data = b;
        bus.rx_done = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_done = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    always @(negedge clk) begin
        if (!reset && prev_start) check("tx_start_width", {31'b0, bus.tx_start}, 32'd0);
        if (!reset && bus.tx_start) begin
            n_tx++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL tx_unexpected: got %0h, expected no transmission", bus.tx_data);
            end else begin
                check("tx_data", {24'b0, bus.tx_data}, {24'b0, exp_q.pop_front()});
            end
        end
        prev_start = bus.tx_start && !reset;
    end

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        n_tx        = 0;
        prev_start  = 1'b0;
        reset       = 1'b1;
        bus.rx_data = 8'h00;
        bus.rx_done = 1'b0;
        bus.tx_busy = 1'b0;
        tick(3);
        check("rst_unlocked", {31'b0, bus.unlocked}, 32'd0);
        check("rst_lockout", {31'b0, bus.lockout}, 32'd0);
        check("rst_fail_count", {30'b0, bus.fail_count}, 32'd0);
        check("rst_tx_start", {31'b0, bus.tx_start}, 32'd0);
        check("rst_tx_data", {24'b0, bus.tx_data}, 32'd0);
        reset = 1'b0;

        // Correct code, then hold expiry.
        exp_q.push_back(ST_OK);
        exp_q.push_back(ST_RELOCK);
        send_str("1416");
        check("check_cycle_locked", {31'b0, bus.unlocked}, 32'd0);
        tick();
        check("e1_unlocked", {31'b0, bus.unlocked}, 32'd1);
        tick();
        check("e2_tx_start", {31'b0, bus.tx_start}, 32'd1);
        check("e2_tx_data", {24'b0, bus.tx_data}, 32'h4F);
        tick(UNLOCK - 1);
        check("hold_last", {31'b0, bus.unlocked}, 32'd1);
        tick();
        check("hold_expired", {31'b0, bus.unlocked}, 32'd0);
        tick();
        check("relock_tx_start", {31'b0, bus.tx_start}, 32'd1);
        check("relock_tx_data", {24'b0, bus.tx_data}, 32'h52);
        tick(2);

        // Wrong codes up to lockout; bytes during lockout dropped.
        exp_q.push_back(ST_FAIL);
        send_str("1234");
        tick();
        check("fail_count_1", {30'b0, bus.fail_count}, 32'd1);
        tick(3);
        exp_q.push_back(ST_FAIL);
        send_str("1234");
        tick();
        check("fail_count_2", {30'b0, bus.fail_count}, 32'd2);
        tick(3);
        exp_q.push_back(ST_LOCK);
        send_str("1234");
        tick();
        check("lockout_set", {31'b0, bus.lockout}, 32'd1);
        check("lockout_fail_clr", {30'b0, bus.fail_count}, 32'd0);
        tick();
        send_str("1416");
        check("lockout_ignores", {31'b0, bus.unlocked}, 32'd0);
        tick(LOCKOUT - 9);
        check("lockout_last", {31'b0, bus.lockout}, 32'd1);
        tick();
        check("lockout_end", {31'b0, bus.lockout}, 32'd0);

        // Star clears a partial entry; manual relock after 10 cycles.
        exp_q.push_back(ST_OK);
        send_str("14*1416");
        tick();
        check("star_clear_unlock", {31'b0, bus.unlocked}, 32'd1);
        tick(11);
        exp_q.push_back(ST_RELOCK);
        send_byte(STAR);
        check("manual_relock", {31'b0, bus.unlocked}, 32'd0);
        tick(UNLOCK);
        check("hold_discarded", {31'b0, bus.unlocked}, 32'd0);

        // Non-digit bytes ignored.
        exp_q.push_back(ST_OK);
        send_str("1a4b16");
        tick();
        check("letters_unlock", {31'b0, bus.unlocked}, 32'd1);
        tick(5);
        exp_q.push_back(ST_RELOCK);
        send_byte(STAR);
        tick(3);

        // Busy transmitter delays the response; byte in RESP dropped.
        bus.tx_busy = 1'b1;
        tx_before = n_tx;
        exp_q.push_back(ST_OK);
        send_str("1416");
        send_byte("9");
        tick(45);
        check("busy_no_start", n_tx, tx_before);
        check("busy_unlocked", {31'b0, bus.unlocked}, 32'd1);
        bus.tx_busy = 1'b0;
        tick();
        check("busy_release_start", {31'b0, bus.tx_start}, 32'd1);
        tick();
        check("busy_single_start", n_tx, tx_before + 1);
        exp_q.push_back(ST_RELOCK);
        send_byte(STAR);
        tick(3);
        exp_q.push_back(ST_OK);
        send_str("1416");
        tick();
        check("after_drop_unlock", {31'b0, bus.unlocked}, 32'd1);
        tick(3);

        // Reset while unlocked.
        reset = 1'b1;
        #1;
        check("rst_unl_unlocked", {31'b0, bus.unlocked}, 32'd0);
        check("rst_unl_tx_data", {24'b0, bus.tx_data}, 32'd0);
        tick();
        reset = 1'b0;
        exp_q.push_back(ST_OK);
        send_str("1416");
        tick();
        check("post_rst_unlock", {31'b0, bus.unlocked}, 32'd1);
        tick(3);

        // Reset while in lockout.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back((i == 2) ? ST_LOCK : ST_FAIL);
            send_str("1234");
            tick(4);
        end
        check("pre_rst_lockout", {31'b0, bus.lockout}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst_lk_lockout", {31'b0, bus.lockout}, 32'd0);
        check("rst_lk_fail_count", {30'b0, bus.fail_count}, 32'd0);
        check("rst_lk_tx_start", {31'b0, bus.tx_start}, 32'd0);
        tick();
        reset = 1'b0;
        exp_q.push_back(ST_OK);
        send_str("1416");
        tick();
        check("post_lk_unlock", {31'b0, bus.unlocked}, 32'd1);

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
        check("queue_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
